custom_bus_matrix_input_stage: RTL and testbench

Master-side input stage of the custom AHB bus matrix: sits between one AHB master port and the output stages it can reach. Registers each accepted address phase into a hold buffer when the target output stage is not granted or not ready, replays it as a held transfer (`held_tran_op`), stalls the master meanwhile, and returns slave data-phase responses (HREADYOUT/HRESP) to the master. It is the counterpart of the output stage's `held_tran_op*`/`active_op*` interface.

---
 rtl/custom_ahb_pkg.sv | 37 +++
 rtl/custom_bus_matrix_input_stage.sv | 131 +++++++++++++
 tb/tb_custom_bus_matrix_input_stage.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/custom_ahb_pkg.sv
// -----------------------------------------------------------------------------
// custom_ahb_pkg
// Shared AHB-Lite encodings for the custom bus matrix blocks.
//   htrans_t     : HTRANS transfer types (IDLE/BUSY/NONSEQ/SEQ)
//   hresp_t      : HRESP responses (OKAY/ERROR)
//   HBURST_INCR  : undefined-length incrementing burst encoding
//   hold_t       : address/control bundle captured by a matrix input stage
// -----------------------------------------------------------------------------
package custom_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    localparam logic [2:0] HBURST_INCR = 3'b001;

    typedef struct packed {
        logic        sel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic [3:0]  master;
        logic        mastlock;
    } hold_t;

endpackage

// File: rtl/custom_bus_matrix_input_stage.sv
// -----------------------------------------------------------------------------
// custom_bus_matrix_input_stage
// Master-side input stage of the custom AHB bus matrix. An accepted address
// phase that cannot be issued immediately (output stage not granted / not
// ready) is captured in a hold register and replayed as a held transfer while
// the master is stalled. Data-phase responses from the owning output stage are
// returned to the master.
//
// Ports:
//   HCLK, HRESETn             clock, asynchronous active-low reset
//   HSELS..HMASTLOCKS, HREADYS master-side address/control and bus HREADY
//   HREADYOUTS, HRESPS        ready / response back to the master
//   active_ip, hready_ip      grant and HREADY of the addressed output stage
//   readyout_ip, resp_ip      data-phase ready / response from output stage
//   sel_op..mastlock_op       address/control presented to output stages
//   held_tran_op              valid transfer presented to output stages
//
// Configuration macro:
//   CUSTOM_BM_INP_SEQ2NSEQ_EN  when defined, a SEQ transfer replayed from the
//                              hold register is presented as NONSEQ/INCR.
// -----------------------------------------------------------------------------
module custom_bus_matrix_input_stage
    import custom_ahb_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSELS,
    input  logic [31:0] HADDRS,
    input  logic [1:0]  HTRANSS,
    input  logic        HWRITES,
    input  logic [2:0]  HSIZES,
    input  logic [2:0]  HBURSTS,
    input  logic [3:0]  HPROTS,
    input  logic [3:0]  HMASTERS,
    input  logic        HMASTLOCKS,
    input  logic        HREADYS,
    output logic        HREADYOUTS,
    output logic        HRESPS,
    input  logic        active_ip,
    input  logic        hready_ip,
    input  logic        readyout_ip,
    input  logic        resp_ip,
    output logic        sel_op,
    output logic [31:0] addr_op,
    output logic [1:0]  trans_op,
    output logic        write_op,
    output logic [2:0]  size_op,
    output logic [2:0]  burst_op,
    output logic [3:0]  prot_op,
    output logic [3:0]  master_op,
    output logic        mastlock_op,
    output logic        held_tran_op
);

    logic  accept;
    logic  issue;
    logic  pend;
    logic  dphase;
    hold_t live;
    hold_t hold_q;
    hold_t presented;

    always_comb begin
        live.sel      = HSELS;
        live.addr     = HADDRS;
        live.trans    = HTRANSS;
        live.write    = HWRITES;
        live.size     = HSIZES;
        live.burst    = HBURSTS;
        live.prot     = HPROTS;
        live.master   = HMASTERS;
        live.mastlock = HMASTLOCKS;
    end

    // Only NONSEQ/SEQ (HTRANS[1] set) are real transfers; IDLE/BUSY get an
    // immediate OKAY and are never held.
    assign accept       = HSELS & HTRANSS[1] & HREADYS;
    assign held_tran_op = pend | accept;
    assign issue        = held_tran_op & active_ip & hready_ip;

    // The master is stalled while pend is set, so accept and pend never
    // overlap and the hold register cannot be overwritten while pending.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend   <= 1'b0;
            dphase <= 1'b0;
            hold_q <= '0;
        end else begin
            if (accept) begin
                hold_q <= live;
            end
            if (accept & ~issue) begin
                pend <= 1'b1;
            end else if (pend & issue) begin
                pend <= 1'b0;
            end
            if (issue) begin
                dphase <= 1'b1;
            end else if (readyout_ip) begin
                dphase <= 1'b0;
            end
        end
    end

    // A replayed SEQ beat follows re-arbitration, so the slave may have seen
    // other masters in between; restarting it as NONSEQ/INCR keeps the burst
    // legal from the slave's point of view.
    always_comb begin
        presented = pend ? hold_q : live;
`ifdef CUSTOM_BM_INP_SEQ2NSEQ_EN
        if (pend && (hold_q.trans == HTRANS_SEQ)) begin
            presented.trans = HTRANS_NONSEQ;
            presented.burst = HBURST_INCR;
        end
`endif
    end

    assign sel_op      = presented.sel | pend;
    assign addr_op     = presented.addr;
    assign trans_op    = presented.trans;
    assign write_op    = presented.write;
    assign size_op     = presented.size;
    assign burst_op    = presented.burst;
    assign prot_op     = presented.prot;
    assign master_op   = presented.master;
    assign mastlock_op = presented.mastlock;

    assign HREADYOUTS = pend ? 1'b0 : (dphase ? readyout_ip : 1'b1);
    assign HRESPS     = (~pend & dphase) ? resp_ip : HRESP_OKAY;

endmodule

// File: tb/tb_custom_bus_matrix_input_stage.sv
// -----------------------------------------------------------------------------
// tb_custom_bus_matrix_input_stage
// Directed testbench for the bus matrix input stage: reset, granted
// pass-through, blocked hold and replay, data-phase waits, ERROR response,
// SEQ replay (with or without CUSTOM_BM_INP_SEQ2NSEQ_EN), IDLE/BUSY handling
// and reset while a transfer is held.
// -----------------------------------------------------------------------------
module tb_custom_bus_matrix_input_stage;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic [3:0]  HMASTERS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic        HRESPS;
    logic        active_ip;
    logic        hready_ip;
    logic        readyout_ip;
    logic        resp_ip;
    logic        sel_op;
    logic [31:0] addr_op;
    logic [1:0]  trans_op;
    logic        write_op;
    logic [2:0]  size_op;
    logic [2:0]  burst_op;
    logic [3:0]  prot_op;
    logic [3:0]  master_op;
    logic        mastlock_op;
    logic        held_tran_op;

    int checks = 0;
    int fails  = 0;

`ifdef CUSTOM_BM_INP_SEQ2NSEQ_EN
    localparam logic [1:0] EXP_HELD_SEQ_TRANS = 2'b10;
    localparam logic [2:0] EXP_HELD_SEQ_BURST = 3'b001;
`else
    localparam logic [1:0] EXP_HELD_SEQ_TRANS = 2'b11;
    localparam logic [2:0] EXP_HELD_SEQ_BURST = 3'b011;
`endif

    custom_bus_matrix_input_stage dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .HSELS        (HSELS),
        .HADDRS       (HADDRS),
        .HTRANSS      (HTRANSS),
        .HWRITES      (HWRITES),
        .HSIZES       (HSIZES),
        .HBURSTS      (HBURSTS),
        .HPROTS       (HPROTS),
        .HMASTERS     (HMASTERS),
        .HMASTLOCKS   (HMASTLOCKS),
        .HREADYS      (HREADYS),
        .HREADYOUTS   (HREADYOUTS),
        .HRESPS       (HRESPS),
        .active_ip    (active_ip),
        .hready_ip    (hready_ip),
        .readyout_ip  (readyout_ip),
        .resp_ip      (resp_ip),
        .sel_op       (sel_op),
        .addr_op      (addr_op),
        .trans_op     (trans_op),
        .write_op     (write_op),
        .size_op      (size_op),
        .burst_op     (burst_op),
        .prot_op      (prot_op),
        .master_op    (master_op),
        .mastlock_op  (mastlock_op),
        .held_tran_op (held_tran_op)
    );

    always #5 HCLK = ~HCLK;

    task set_idle();
        HSELS       = 1'b0;
        HADDRS      = 32'h0;
        HTRANSS     = 2'b00;
        HWRITES     = 1'b0;
        HSIZES      = 3'b010;
        HBURSTS     = 3'b000;
        HPROTS      = 4'b0011;
        HMASTERS    = 4'h1;
        HMASTLOCKS  = 1'b0;
        HREADYS     = 1'b1;
        active_ip   = 1'b0;
        hready_ip   = 1'b1;
        readyout_ip = 1'b1;
        resp_ip     = 1'b0;
    endtask

    task start_nonseq(input logic [31:0] addr, input logic write, input logic grant);
        HSELS     = 1'b1;
        HTRANSS   = 2'b10;
        HADDRS    = addr;
        HWRITES   = write;
        HBURSTS   = 3'b000;
        HREADYS   = 1'b1;
        active_ip = grant;
    endtask

    // Advance to just after the next rising edge.
    task step();
        @(posedge HCLK);
        #1;
    endtask

    // Wait to the falling edge to sample combinational outputs.
    task settle();
        @(negedge HCLK);
    endtask

    task test_reset();
        HRESETn = 1'b0;
        set_idle();
        #2;
        checks++; if (HREADYOUTS !== 1'b1) begin fails++; $display("FAIL reset_hreadyouts: got %0b expected 1", HREADYOUTS); end
        checks++; if (HRESPS !== 1'b0) begin fails++; $display("FAIL reset_hresps: got %0b expected 0", HRESPS); end
        checks++; if (held_tran_op !== 1'b0) begin fails++; $display("FAIL reset_held_idle: got %0b expected 0", held_tran_op); end
        HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h0000_1234;
        #1;
        checks++; if (held_tran_op !== 1'b1) begin fails++; $display("FAIL reset_held_accept: got %0b expected 1", held_tran_op); end
        checks++; if (addr_op !== 32'h0000_1234) begin fails++; $display("FAIL reset_addr_live: got %h expected 00001234", addr_op); end
        set_idle();
        step();
        HRESETn = 1'b1;
        step();
    endtask

    task test_pass_through();
        start_nonseq(32'h2000_0000, 1'b1, 1'b1);
        settle();
        checks++; if (held_tran_op !== 1'b1) begin fails++; $display("FAIL pt_held: got %0b expected 1", held_tran_op); end
        checks++; if (addr_op !== 32'h2000_0000) begin fails++; $display("FAIL pt_addr: got %h expected 20000000", addr_op); end
        checks++; if (trans_op !== 2'b10) begin fails++; $display("FAIL pt_trans: got %b expected 10", trans_op); end
        checks++; if (write_op !== 1'b1) begin fails++; $display("FAIL pt_write: got %0b expected 1", write_op); end
        checks++; if (sel_op !== 1'b1) begin fails++; $display("FAIL pt_sel: got %0b expected 1", sel_op); end
        checks++; if (master_op !== 4'h1) begin fails++; $display("FAIL pt_master: got %h expected 1", master_op); end
        checks++; if (HREADYOUTS !== 1'b1) begin fails++; $display("FAIL pt_hreadyouts_addr: got %0b expected 1", HREADYOUTS); end
        step();
        set_idle();
        settle();
        checks++; if (HREADYOUTS !== 1'b1) begin fails++; $display("FAIL pt_hreadyouts_data: got %0b expected 1", HREADYOUTS); end
        checks++; if (held_tran_op !== 1'b0) begin fails++; $display("FAIL pt_held_after: got %0b expected 0", held_tran_op); end
        step();
    endtask

    task test_data_wait();
        start_nonseq(32'h2000_0004, 1'b0, 1'b1);
        step();
        set_idle();
        readyout_ip = 1'b0;
        settle();
        checks++; if (HREADYOUTS !== 1'b0) begin fails++; $display("FAIL dw_wait1: got %0b expected 0", HREADYOUTS); end
        step();
        settle();
        checks++; if (HREADYOUTS !== 1'b0) begin fails++; $display("FAIL dw_wait2: got %0b expected 0", HREADYOUTS); end
        step();
        readyout_ip = 1'b1;
        settle();
        checks++; if (HREADYOUTS !== 1'b1) begin fails++; $display("FAIL dw_done: got %0b expected 1", HREADYOUTS); end
        step();
        readyout_ip = 1'b0;
        settle();
        checks++; if (HREADYOUTS !== 1'b1) begin fails++; $display("FAIL dw_cleared: got %0b expected 1", HREADYOUTS); end
        readyout_ip = 1'b1;
        step();
    endtask

    task test_blocked();
        start_nonseq(32'h4000_0010, 1'b0, 1'b0);
        settle();
        checks++; if (held_tran_op !== 1'b1) begin fails++; $display("FAIL blk_held0: got %0b expected 1", held_tran_op); end
        checks++; if (addr_op !== 32'h4000_0010) begin fails++; $display("FAIL blk_addr0: got %h expected 40000010", addr_op); end
        checks++; if (HREADYOUTS !== 1'b1) begin fails++; $display("FAIL blk_hready0: got %0b expected 1", HREADYOUTS); end
        step();
        HADDRS  = 32'hDEAD_0000;
        HTRANSS = 2'b00;
        HREADYS = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            active_ip = (i == 3);
            settle();
            checks++; if (HREADYOUTS !== 1'b0) begin fails++; $display("FAIL blk_stall%0d: got %0b expected 0", i, HREADYOUTS); end
            checks++; if (addr_op !== 32'h4000_0010) begin fails++; $display("FAIL blk_addr%0d: got %h expected 40000010", i, addr_op); end
            checks++; if (trans_op !== 2'b10) begin fails++; $display("FAIL blk_trans%0d: got %b expected 10", i, trans_op); end
            checks++; if (held_tran_op !== 1'b1) begin fails++; $display("FAIL blk_held%0d: got %0b expected 1", i, held_tran_op); end
            step();
        end
        set_idle();
        settle();
        checks++; if (HREADYOUTS !== 1'b1) begin fails++; $display("FAIL blk_released: got %0b expected 1", HREADYOUTS); end
        checks++; if (held_tran_op !== 1'b0) begin fails++; $display("FAIL blk_held_done: got %0b expected 0", held_tran_op); end
        checks++; if (addr_op !== 32'h0) begin fails++; $display("FAIL blk_addr_live: got %h expected 00000000", addr_op); end
        step();
    endtask

    task test_error();
        start_nonseq(32'h3000_0000, 1'b1, 1'b1);
        step();
        set_idle();
        readyout_ip = 1'b0;
        resp_ip     = 1'b1;
        settle();
        checks++; if (HRESPS !== 1'b1) begin fails++; $display("FAIL err_resp1: got %0b expected 1", HRESPS); end
        checks++; if (HREADYOUTS !== 1'b0) begin fails++; $display("FAIL err_ready1: got %0b expected 0", HREADYOUTS); end
        step();
        readyout_ip = 1'b1;
        settle();
        checks++; if (HRESPS !== 1'b1) begin fails++; $display("FAIL err_resp2: got %0b expected 1", HRESPS); end
        checks++; if (HREADYOUTS !== 1'b1) begin fails++; $display("FAIL err_ready2: got %0b expected 1", HREADYOUTS); end
        step();
        settle();
        checks++; if (HRESPS !== 1'b0) begin fails++; $display("FAIL err_resp_after: got %0b expected 0", HRESPS); end
        resp_ip = 1'b0;
        step();
    endtask

    task test_seq_held();
        HSELS     = 1'b1;
        HTRANSS   = 2'b11;
        HBURSTS   = 3'b011;
        HADDRS    = 32'h4000_0014;
        HREADYS   = 1'b1;
        active_ip = 1'b0;
        settle();
        checks++; if (trans_op !== 2'b11) begin fails++; $display("FAIL seq_live_trans: got %b expected 11", trans_op); end
        checks++; if (burst_op !== 3'b011) begin fails++; $display("FAIL seq_live_burst: got %b expected 011", burst_op); end
        step();
        HTRANSS = 2'b00;
        HBURSTS = 3'b000;
        HREADYS = 1'b0;
        settle();
        checks++; if (trans_op !== EXP_HELD_SEQ_TRANS) begin fails++; $display("FAIL seq_held_trans: got %b expected %b", trans_op, EXP_HELD_SEQ_TRANS); end
        checks++; if (burst_op !== EXP_HELD_SEQ_BURST) begin fails++; $display("FAIL seq_held_burst: got %b expected %b", burst_op, EXP_HELD_SEQ_BURST); end
        checks++; if (addr_op !== 32'h4000_0014) begin fails++; $display("FAIL seq_held_addr: got %h expected 40000014", addr_op); end
        step();
        active_ip = 1'b1;
        step();
        set_idle();
        step();
    endtask

    task test_idle_busy();
        HSELS     = 1'b1;
        HTRANSS   = 2'b01;
        active_ip = 1'b1;
        settle();
        checks++; if (held_tran_op !== 1'b0) begin fails++; $display("FAIL busy_held: got %0b expected 0", held_tran_op); end
        checks++; if (HREADYOUTS !== 1'b1) begin fails++; $display("FAIL busy_ready: got %0b expected 1", HREADYOUTS); end
        step();
        HTRANSS     = 2'b00;
        readyout_ip = 1'b0;
        resp_ip     = 1'b1;
        settle();
        checks++; if (HREADYOUTS !== 1'b1) begin fails++; $display("FAIL busy_no_dphase: got %0b expected 1", HREADYOUTS); end
        checks++; if (HRESPS !== 1'b0) begin fails++; $display("FAIL busy_okay: got %0b expected 0", HRESPS); end
        set_idle();
        step();
    endtask

    task test_reset_mid_hold();
        start_nonseq(32'h5000_0000, 1'b1, 1'b0);
        step();
        HSELS   = 1'b0;
        HTRANSS = 2'b00;
        HREADYS = 1'b0;
        settle();
        checks++; if (HREADYOUTS !== 1'b0) begin fails++; $display("FAIL rst_hold_stall: got %0b expected 0", HREADYOUTS); end
        checks++; if (sel_op !== 1'b1) begin fails++; $display("FAIL rst_hold_sel: got %0b expected 1", sel_op); end
        #1;
        HRESETn = 1'b0;
        #1;
        checks++; if (held_tran_op !== 1'b0) begin fails++; $display("FAIL rst_held_drop: got %0b expected 0", held_tran_op); end
        checks++; if (HREADYOUTS !== 1'b1) begin fails++; $display("FAIL rst_ready: got %0b expected 1", HREADYOUTS); end
        checks++; if (sel_op !== 1'b0) begin fails++; $display("FAIL rst_sel: got %0b expected 0", sel_op); end
        step();
        HRESETn = 1'b1;
        set_idle();
        step();
        settle();
        checks++; if (held_tran_op !== 1'b0) begin fails++; $display("FAIL rst_after_held: got %0b expected 0", held_tran_op); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_data_wait();
        test_blocked();
        test_error();
        test_seq_held();
        test_idle_busy();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
